shifter_pipe: RTL and testbench
===============================

SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data width; must be a power of two, at least 4.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), default 4, shift-amount width and pipeline depth.
REQ-003 SHALL have port clk input 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid input 1: operand set present.
REQ-006 SHALL have port in_ready output 1: operand set accepted this cycle when high with in_valid.
REQ-007 SHALL have port a input WIDTH: value to shift.
REQ-008 SHALL have port b input WIDTH: shift amount; only b[SHW-1:0] used.
REQ-009 SHALL have port mode input 2: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 SHALL have port flush input 1: synchronous discard of all in-flight operations.
REQ-011 SHALL have port out_valid output 1: r and z hold a valid result.
REQ-012 SHALL have port out_ready input 1: consumer accepts the result.
REQ-013 SHALL have port r output WIDTH: shifted result.
REQ-014 SHALL have port z output 1: high when r is all zero.
REQ-015 SHALL have port busy output 1: any stage holds a valid operation.

Function
REQ-016 SHALL implement SHW registered stages; stage k shifts by 2^k when amt[k]=1, else passes through.
REQ-017 SHALL give latency exactly SHW cycles from input handshake to out_valid when not stalled (4 cycles at WIDTH=16).
REQ-018 SHALL sustain throughput of one operation per cycle.
REQ-019 SHALL define advance = out_ready OR NOT out_valid; in_ready = advance; all stages shift together only on advance.
REQ-020 SHALL hold every stage's data, mode, amount and valid unchanged while advance=0; no loss, no duplication, order preserved.
REQ-021 SHALL zero-fill vacated bits for SLL and SRL.
REQ-022 SHALL fill vacated bits for SRA with bit WIDTH-1 of the original a, carried through all stages.
REQ-023 SHALL wrap bits shifted out of the MSB into the LSB for ROL.
REQ-024 SHALL pass a unchanged for amount 0 in every mode.
REQ-025 SHALL compute z combinationally from the final stage register.
REQ-026 SHALL clear all stage valid bits on a cycle with flush=1; an operation presented that same cycle is also discarded.
REQ-027 SHALL keep out_valid low while flush=1, regardless of out_ready.
REQ-028 SHALL assert busy whenever any stage valid bit is 1.

Reset
REQ-029 SHALL, on rst, immediately clear all valid bits and stage data to 0, giving out_valid=0, r=0, z=1, busy=0, in_ready=1.
REQ-030 SHALL discard every in-flight operation when reset is asserted mid-operation; no result appears after deassertion.

Configuration
REQ-031 SHALL gate rotate support with macro SHIFTER_ROTATE_EN.
REQ-032 SHALL, with SHIFTER_ROTATE_EN defined, execute mode 11 as ROL per REQ-023.
REQ-033 SHALL, without SHIFTER_ROTATE_EN, execute mode 11 exactly as SLL and omit the wrap logic.

Structure
REQ-034 SHALL place the mode encoding constants (SLL, SRL, SRA, ROL) in shared package shifter_pkg.
REQ-035 SHALL instantiate sub-module shifter_stage SHW times via generate; parameters WIDTH and stage index k.

Verification
REQ-036 SHALL test SLL: WIDTH=16, a=0x0001, b=0x000F, mode SLL -> r=0x8000, z=0, out_valid exactly 4 cycles after accept.
REQ-037 SHALL test SRA and SRL: a=0x8000, b=3; SRA -> 0xF000, SRL -> 0x1000; a=0x0004, b=0x0013, SRL -> 0x0000 with z=1 (only b[3:0]=3 used).
REQ-038 SHALL test rotate: a=0x8001, b=1, mode ROL -> 0x0003 with macro, 0x0002 without.
REQ-039 SHALL test backpressure: 6 back-to-back ops with amounts 0..5, out_ready held low 3 cycles mid-stream -> in_ready low during the stall, all 6 results in order, none lost or repeated.
REQ-040 SHALL test rst mid-flight: rst asserted with 3 ops in flight -> out_valid=0, r=0, busy=0 immediately; no output after release until new input.
REQ-041 SHALL test flush: flush for 1 cycle with pipe full -> busy=0 next cycle; next accepted op emerges after 4 cycles.

Source files
------------

// File: rtl/shifter_pkg.sv
// shifter_pkg: shared mode encodings for shifter_pipe and its stages.
package shifter_pkg;
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;
endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one registered barrel-shifter stage; shifts by 2^K when amt[K] is set.
// Ports: clk, rst (async, active-high), en (advance), flush; d/mode/amt/sign/valid from the
// previous stage, q/q_mode/q_amt/q_sign/q_valid registered towards the next stage.
// Macro SHIFTER_ROTATE_EN enables the rotate wrap path; otherwise rotate behaves as SLL.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K = 0,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   amt,
    input  logic             sign,
    input  logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       q_mode,
    output logic [SHW-1:0]   q_amt,
    output logic             q_sign,
    output logic             q_valid
);
    localparam int S = 1 << K;

    logic [WIDTH-1:0] shl, shr, sra, rol, shifted;

    always_comb begin
        shl = d << S;
        shr = d >> S;
        // sign is the original operand MSB, so the fill is correct even if earlier stages passed through
        sra = sign ? ~(~d >> S) : shr;
`ifdef SHIFTER_ROTATE_EN
        rol = shl | (d >> (WIDTH - S));
`else
        rol = shl;
`endif
        shifted = !amt[K] ? d :
                  mode == MODE_SRL ? shr :
                  mode == MODE_SRA ? sra :
                  mode == MODE_ROL ? rol : shl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_mode  <= '0;
            q_amt   <= '0;
            q_sign  <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            if (en) begin
                q      <= shifted;
                q_mode <= mode;
                q_amt  <= amt;
                q_sign <= sign;
            end
            q_valid <= flush ? 1'b0 : en ? valid : q_valid;
        end
    end
endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: SHW-stage pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready flow control.
// Ports: clk, rst (async, active-high); in_valid/in_ready with operands a, b (b[SHW-1:0] used), mode;
// flush discards in-flight work; out_valid/out_ready with result r and zero flag z; busy.
// Macro SHIFTER_ROTATE_EN enables rotate for mode 11; otherwise mode 11 acts as SLL.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW:0][WIDTH-1:0] d;
    logic [SHW:0][1:0]       m;
    logic [SHW:0][SHW-1:0]   amt;
    logic [SHW:0]            sg;
    logic [SHW:0]            v;
    logic                    advance;
    logic                    unused_bits;

    assign d[0]   = a;
    assign m[0]   = mode;
    assign amt[0] = b[SHW-1:0];
    assign sg[0]  = a[WIDTH-1];
    assign v[0]   = in_valid;

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            shifter_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
                .clk(clk), .rst(rst), .en(advance), .flush(flush),
                .d(d[k]), .mode(m[k]), .amt(amt[k]), .sign(sg[k]), .valid(v[k]),
                .q(d[k+1]), .q_mode(m[k+1]), .q_amt(amt[k+1]), .q_sign(sg[k+1]), .q_valid(v[k+1])
            );
        end
    endgenerate

    // flush masks the output so a flushed result is never handed over
    assign out_valid   = v[SHW] & ~flush;
    assign advance     = out_ready | ~out_valid;
    assign in_ready    = advance;
    assign r           = d[SHW];
    assign z           = ~|d[SHW];
    assign busy        = |v[SHW:1];
    assign unused_bits = ^{b[WIDTH-1:SHW], m[SHW], amt[SHW], sg[SHW]};
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: randomized and directed self-checking bench for shifter_pipe against a behavioural model.
module tb_shifter_pipe;
    localparam int W = 16;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic [1:0]   mode = '0;
    logic         in_ready, out_valid, z, busy;
    logic [W-1:0] r;
    int           checks = 0, errors = 0;
    logic [W-1:0] exp_q[$], got_q[$];
    logic         acc;

    shifter_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .mode(mode),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .r(r), .z(z), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] s, input logic [1:0] m);
        int n;
        logic signed [W-1:0] sx;
        n  = int'(s[3:0]);
        sx = x;
        if (n == 0) return x;
        case (m)
            2'd1: return x >> n;
            2'd2: return sx >>> n;
`ifdef SHIFTER_ROTATE_EN
            2'd3: return (x << n) | (x >> (W - n));
`endif
            default: return x << n;
        endcase
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [1:0] im, input logic ordy);
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; mode = im; out_ready = ordy;
        #1;
        if (out_valid && out_ready) got_q.push_back(r);
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(ia, ib, im));
    endtask

    task automatic drain(input int want);
        int n;
        n = 0;
        while (got_q.size() < want && n < 100) begin
            step(1'b0, '0, '0, 2'd0, 1'b1);
            n++;
        end
    endtask

    task automatic single(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] im,
                          output logic [W-1:0] res, output logic rz, output int lat);
        step(1'b1, ia, ib, im, 1'b1);
        lat = 0;
        do begin
            step(1'b0, '0, '0, 2'd0, 1'b1);
            lat++;
        end while (!out_valid && lat < 20);
        res = r;
        rz  = z;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (r !== '0) begin errors++; $display("FAIL reset_r: got %h expected 0000", r); end
        if (z !== 1'b1) begin errors++; $display("FAIL reset_z: got %b expected 1", z); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sll;
        logic [W-1:0] res;
        logic rz;
        int lat;
        single(16'h0001, 16'h000F, 2'd0, res, rz, lat);
        checks += 4;
        if (res !== 16'h8000) begin errors++; $display("FAIL sll_r: got %h expected 8000", res); end
        if (res !== model(16'h0001, 16'h000F, 2'd0)) begin errors++; $display("FAIL sll_model: got %h expected %h", res, model(16'h0001, 16'h000F, 2'd0)); end
        if (rz !== 1'b0) begin errors++; $display("FAIL sll_z: got %b expected 0", rz); end
        if (lat !== 4) begin errors++; $display("FAIL sll_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_sra_srl;
        logic [W-1:0] res;
        logic rz;
        int lat;
        single(16'h8000, 16'h0003, 2'd2, res, rz, lat);
        checks += 2;
        if (res !== 16'hF000) begin errors++; $display("FAIL sra_r: got %h expected f000", res); end
        if (lat !== 4) begin errors++; $display("FAIL sra_latency: got %0d expected 4", lat); end
        single(16'h8000, 16'h0003, 2'd1, res, rz, lat);
        checks++;
        if (res !== 16'h1000) begin errors++; $display("FAIL srl_r: got %h expected 1000", res); end
        single(16'h0004, 16'h0013, 2'd1, res, rz, lat);
        checks += 2;
        if (res !== 16'h0000) begin errors++; $display("FAIL srl_mask_r: got %h expected 0000", res); end
        if (rz !== 1'b1) begin errors++; $display("FAIL srl_mask_z: got %b expected 1", rz); end
    endtask

    task automatic test_rotate;
        logic [W-1:0] res, want;
        logic rz;
        int lat;
`ifdef SHIFTER_ROTATE_EN
        want = 16'h0003;
`else
        want = 16'h0002;
`endif
        single(16'h8001, 16'h0001, 2'd3, res, rz, lat);
        checks++;
        if (res !== want) begin errors++; $display("FAIL rotate_r: got %h expected %h", res, want); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va[6];
        logic [1:0] vm[6];
        int i, n;
        exp_q.delete();
        got_q.delete();
        foreach (va[k]) begin
            va[k] = 16'($urandom);
            vm[k] = 2'($urandom_range(0, 3));
        end
        i = 0;
        n = 0;
        while (i < 6 && n < 30) begin
            step(1'b1, va[i], 16'(i), vm[i], !(n >= 5 && n <= 7));
            if (n >= 5 && n <= 7) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready step %0d: got %b expected 0", n, in_ready); end
            end
            if (acc) i++;
            n++;
        end
        drain(6);
        checks += 2;
        if (exp_q.size() != 6) begin errors++; $display("FAIL b2b_accepted: got %0d expected 6", exp_q.size()); end
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k])
                begin errors++; $display("FAIL b2b_result %0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]); end
        end
    endtask

    task automatic test_rst_midflight;
        int seen;
        repeat (3) step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        if (r !== '0) begin errors++; $display("FAIL rst_mid_r: got %h expected 0000", r); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            step(1'b0, '0, '0, 2'd0, 1'b1);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_ghost_output: got %0d expected 0", seen); end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_flush;
        logic [W-1:0] res, ia, ib;
        logic [1:0] im;
        logic rz;
        int lat;
        repeat (4) step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h0001;
        flush = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        exp_q.delete();
        got_q.delete();
        ia = 16'($urandom);
        ib = 16'($urandom);
        im = 2'($urandom_range(0, 3));
        single(ia, ib, im, res, rz, lat);
        checks += 2;
        if (lat !== 4) begin errors++; $display("FAIL flush_next_latency: got %0d expected 4", lat); end
        if (res !== model(ia, ib, im)) begin errors++; $display("FAIL flush_next_r: got %h expected %h", res, model(ia, ib, im)); end
    endtask

    task automatic test_random;
        exp_q.delete();
        got_q.delete();
        repeat (300)
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0);
        drain(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k])
                begin errors++; $display("FAIL random_result %0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 'x, exp_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_rotate();
        test_back_to_back();
        test_rst_midflight();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
